mmio_data_responder: RTL

//  Responder side of the single-cycle MIPS data bus (memwrite/dataadr/writedata/readdata).

---
 rtl/mmio_data_responder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_data_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_data_responder
//  Description : Data-bus responder for a single-cycle MIPS core. Serves a
//                word RAM plus a 16-byte MMIO window:
//                  +0x0 CONSOLE     write pushes a byte into the TX FIFO
//                  +0x4 STATUS      {count, unmapped_err, overflow, full, empty}
//                  +0x8 CYCLE       free-running cycle counter (writable)
//                  +0xC TEST_RESULT sets sticky halt and pass/fail flags
//  Ports       : clk, reset (sync, active-high)
//                memwrite, dataadr, writedata -> store request
//                readdata                      <- combinational load data
//                con_data/con_valid/con_ready  <- console drain (valid/ready)
//                halt/pass/fail                <- sticky test outcome flags
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_data_responder #(
    parameter int          RAM_WORDS  = 64,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_VALUE = 32'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        halt,
    output logic        pass,
    output logic        fail
);

    localparam int          c_AW        = $clog2(RAM_WORDS);
    localparam int          c_PW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] c_RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [c_PW:0] c_FULL    = (c_PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_REG_CONSOLE = 2'd0;
    localparam logic [1:0] c_REG_STATUS  = 2'd1;
    localparam logic [1:0] c_REG_CYCLE   = 2'd2;
    localparam logic [1:0] c_REG_RESULT  = 2'd3;

    // Storage (no reset: RAM contents and FIFO payload survive reset)
    logic [31:0] ram_q  [RAM_WORDS];
    logic [7:0]  fifo_q [FIFO_DEPTH];

    // Control state
    logic [c_PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [c_PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [c_PW:0]   count_q,    count_d;
    logic            overflow_q, overflow_d;
    logic            unmap_q,    unmap_d;
    logic [31:0]     cycle_q,    cycle_d;
    logic [31:0]     result_q,   result_d;
    logic            halt_q,     halt_d;
    logic            pass_q,     pass_d;
    logic            fail_q,     fail_d;

    // Address decode
    logic            w_ram_hit;
    logic            w_io_hit;
    logic [1:0]      w_reg;
    logic [c_AW-1:0] w_ram_idx;
    logic            w_we;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push_ok;

    assign w_ram_hit = (dataadr < c_RAM_BYTES);
    assign w_io_hit  = !w_ram_hit && (dataadr[31:4] == IO_BASE[31:4]);
    assign w_reg     = dataadr[3:2];
    assign w_ram_idx = dataadr[c_AW+1:2];

    // Halt blocks every store, RAM included
    assign w_we      = memwrite && !halt_q;

    assign w_full     = (count_q == c_FULL);
    assign w_empty    = (count_q == '0);
    assign w_pop      = con_valid && con_ready;
    assign w_push_req = w_we && w_io_hit && (w_reg == c_REG_CONSOLE);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    assign con_valid = !w_empty;
    assign con_data  = fifo_q[rd_ptr_q];
    assign halt      = halt_q;
    assign pass      = pass_q;
    assign fail      = fail_q;

    always_comb begin
        readdata = 32'h0;
        if (w_ram_hit) begin
            readdata = ram_q[w_ram_idx];
        end else if (w_io_hit) begin
            case (w_reg)
                c_REG_STATUS: readdata = {20'b0, 8'(count_q), unmap_q, overflow_q, w_full, w_empty};
                c_REG_CYCLE:  readdata = cycle_q;
                c_REG_RESULT: readdata = result_q;
                default:      readdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        unmap_d    = unmap_q;
        cycle_d    = cycle_q;
        result_d   = result_q;
        halt_d     = halt_q;
        pass_d     = pass_q;
        fail_d     = fail_q;

        if (w_pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (w_push_req && !w_push_ok) overflow_d = 1'b1;

        if (!halt_q) cycle_d = cycle_q + 32'd1;

        if (w_we && w_io_hit) begin
            case (w_reg)
                c_REG_STATUS: begin
                    overflow_d = 1'b0;
                    unmap_d    = 1'b0;
                end
                c_REG_CYCLE:  cycle_d = writedata;
                c_REG_RESULT: begin
                    result_d = writedata;
                    halt_d   = 1'b1;
                    if (writedata == PASS_VALUE) pass_d = 1'b1;
                    else                         fail_d = 1'b1;
                end
                default: ;
            endcase
        end else if (w_we && !w_ram_hit) begin
            unmap_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            unmap_q    <= 1'b0;
            cycle_q    <= 32'h0;
            result_q   <= 32'h0;
            halt_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            unmap_q    <= unmap_d;
            cycle_q    <= cycle_d;
            result_q   <= result_d;
            halt_q     <= halt_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we && w_ram_hit) ram_q[w_ram_idx] <= writedata;
        if (!reset && w_push_ok) fifo_q[wr_ptr_q] <= writedata[7:0];
    end

endmodule
`default_nettype wire
